udp_parse_ctrl: RTL and testbench
=================================

// Module: udp_parse_ctrl
// PURPOSE
// Byte-serial Ethernet/IPv4/UDP parse sequencer. Consumes raw frame bytes (pcap headers already
// stripped upstream) from a FWFT input FIFO, walks the 14-byte ETH, 20-byte IP and 8-byte UDP
// headers with a byte counter, checks header fields against global_params, and forwards only the
// UDP payload to an output FIFO. Sits between the pcap frame splitter and the payload consumer.
// PARAMETERS
// CNT_WIDTH      16     width of byte counter, payload counter and packet counters
// FILTER_PORT    0      1: additionally drop packets whose UDP dst port != DST_PORT
// DST_PORT       16'h0  UDP dst port accepted when FILTER_PORT=1
// PORTS
// clock          in   1          single clock, all logic rising-edge
// reset_n        in   1          asynchronous, active-low reset
// in_dout        in   8          frame byte (FWFT: valid whenever in_empty=0)
// in_sof/in_eof  in   1 each     first/last byte of frame, aligned with in_dout
// in_empty       in   1          input FIFO empty
// in_rd_en       out  1          pop input byte this cycle
// out_din        out  8          payload byte
// out_sof/out_eof out 1 each     first/last payload byte markers
// out_wr_en      out  1          push payload byte this cycle
// out_full       in   1          output FIFO full
// hdr_valid      out  1          1-cycle pulse: header accepted, fields below stable until next pulse
// ip_src/ip_dst  out  32 each    IPv4 source/destination address
// udp_src/udp_dst out 16 each    UDP ports
// udp_len        out  16         UDP length field (header + payload)
// pkt_drop       out  1          1-cycle pulse when a frame is rejected or truncated
// pkt_cnt/drop_cnt out CNT_WIDTH accepted / rejected frame counters (saturating)
// BEHAVIOUR
// - Reset: state=IDLE; all outputs, field registers and counters 0.
// - Byte consumed iff in_rd_en=1. in_rd_en = !in_empty && (state!=PAYLOAD || out_full==0).
// - Payload pass-through is combinational: out_din=in_dout, out_wr_en=in_rd_en in PAYLOAD while
//   pay_cnt < udp_len-8; zero latency. No byte lost or duplicated under any out_full pattern.
// - States: IDLE -> HDR (counting bytes 0..41) -> PAYLOAD -> TRAIL -> IDLE; any -> DROP -> IDLE.
//   IDLE: discard bytes until in_sof; the sof byte is byte 0 and moves to HDR (byte_cnt=1).
//   HDR byte offsets: 12-13 ethertype; 14 ver/IHL; 23 protocol; 26-29 ip_src; 30-33 ip_dst;
//   34-35 udp_src; 36-37 udp_dst; 38-39 udp_len; all big-endian, captured as consumed.
//   Check on the consuming cycle: ethertype==IP_PROTOCOL_DEF (byte 13), ver==IP_VERSION_DEF and
//   IHL==IP_HEADER_LENGTH_DEF (byte 14), protocol==UDP_PROTOCOL_DEF (byte 23), udp_len>=8 (byte 39),
//   udp_dst==DST_PORT if FILTER_PORT (byte 37). Fail -> DROP, pkt_drop pulse, drop_cnt+1.
//   Byte 41 consumed: hdr_valid pulse next cycle, pkt_cnt+1; -> PAYLOAD, or TRAIL if udp_len==8.
//   PAYLOAD: out_sof on first payload byte; out_eof on byte udp_len-8 or on in_eof, whichever
//   first; then -> TRAIL (remaining bytes are Ethernet padding), or IDLE if that byte had in_eof.
//   TRAIL/DROP: consume and discard until in_eof byte inclusive, then IDLE.
// - in_eof in HDR (frame < 42 bytes) -> pkt_drop, drop_cnt+1, IDLE. in_eof in PAYLOAD before
//   udp_len-8 bytes -> out_eof on that byte, pkt_drop pulse, counts as accepted (pkt_cnt already +1).
// - in_sof outside IDLE is ignored; states leave only via in_eof or header failure.
// - Single-byte payload: out_sof and out_eof both 1 on the same byte.
// - Counters saturate at all-ones. reset_n low mid-frame: immediate return to IDLE, outputs 0;
//   remaining bytes of that frame discarded until next in_sof.
// TESTING
// 1 Valid frame, udp_len=16'h000C, 4 payload bytes A1..A4, out_full=0 -> out_wr_en x4, sof on A1,
//   eof on A4, hdr_valid once, pkt_cnt=1, ip_src/ip_dst/ports match stimulus.
// 2 Ethertype 16'h86DD -> no out_wr_en, pkt_drop pulse after byte 13, drop_cnt=1, IDLE after eof.
// 3 60-byte frame (padding), udp_len=10 -> exactly 2 payload bytes written, padding discarded, IDLE.
// 4 Test 1 with out_full toggling every cycle and in_empty random -> identical output byte stream.
// 5 Frame ending at byte 30 -> pkt_drop, drop_cnt+1; next back-to-back valid frame parsed correctly.
// 6 reset_n low during PAYLOAD -> all outputs 0 asynchronously; next frame parsed normally.

Source files
------------

// File: rtl/udp_parse_ctrl.sv
// udp_parse_ctrl: byte-serial Ethernet/IPv4/UDP header walker.
// Pops frame bytes from a FWFT FIFO, validates the ETH/IP/UDP headers and
// streams only the UDP payload to the output FIFO with zero latency.
module udp_parse_ctrl #(
  parameter int          CNT_WIDTH   = 16,
  parameter bit          FILTER_PORT = 1'b0,
  parameter logic [15:0] DST_PORT    = 16'h0000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [7:0]           in_dout,
  input  logic                 in_sof,
  input  logic                 in_eof,
  input  logic                 in_empty,
  output logic                 in_rd_en,
  output logic [7:0]           out_din,
  output logic                 out_sof,
  output logic                 out_eof,
  output logic                 out_wr_en,
  input  logic                 out_full,
  output logic                 hdr_valid,
  output logic [31:0]          ip_src,
  output logic [31:0]          ip_dst,
  output logic [15:0]          udp_src,
  output logic [15:0]          udp_dst,
  output logic [15:0]          udp_len,
  output logic                 pkt_drop,
  output logic [CNT_WIDTH-1:0] pkt_cnt,
  output logic [CNT_WIDTH-1:0] drop_cnt
);

  localparam logic [15:0] IP_PROTOCOL_DEF      = 16'h0800;
  localparam logic [3:0]  IP_VERSION_DEF       = 4'd4;
  localparam logic [3:0]  IP_HEADER_LENGTH_DEF = 4'd5;
  localparam logic [7:0]  UDP_PROTOCOL_DEF     = 8'h11;
  localparam logic [CNT_WIDTH-1:0] HDR_LAST    = CNT_WIDTH'(41);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAYLOAD, S_TRAIL, S_DROP} state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
  logic [CNT_WIDTH-1:0] pay_cnt_q, pay_cnt_d;
  logic [7:0]           eth_hi_q, eth_hi_d;
  logic [31:0]          cap_ip_src_q, cap_ip_src_d, cap_ip_dst_q, cap_ip_dst_d;
  logic [15:0]          cap_udp_src_q, cap_udp_src_d, cap_udp_dst_q, cap_udp_dst_d;
  logic [15:0]          cap_udp_len_q, cap_udp_len_d;
  logic [31:0]          ip_src_q, ip_src_d, ip_dst_q, ip_dst_d;
  logic [15:0]          udp_src_q, udp_src_d, udp_dst_q, udp_dst_d, udp_len_q, udp_len_d;
  logic                 hdr_valid_q, hdr_valid_d, pkt_drop_q, pkt_drop_d;
  logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d, drop_cnt_q, drop_cnt_d;

  logic                 hdr_fail_s;
  logic [15:0]          pay_len_s;
  logic                 pay_last_s;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    sat_inc = (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Payload framing and FIFO handshakes; forced low while reset is held.
  assign pay_len_s  = cap_udp_len_q - 16'd8;
  assign pay_last_s = (pay_cnt_q == CNT_WIDTH'(pay_len_s - 16'd1));
  assign in_rd_en   = reset_n && !in_empty && ((state_q != S_PAYLOAD) || !out_full);
  assign out_wr_en  = in_rd_en && (state_q == S_PAYLOAD);
  assign out_din    = out_wr_en ? in_dout : 8'h00;
  assign out_sof    = out_wr_en && (pay_cnt_q == '0);
  assign out_eof    = out_wr_en && (pay_last_s || in_eof);

  // Header field check evaluated on the byte that completes each field.
  always_comb begin
    hdr_fail_s = 1'b0;
    case (byte_cnt_q)
      CNT_WIDTH'(13): hdr_fail_s = ({eth_hi_q, in_dout} != IP_PROTOCOL_DEF);
      CNT_WIDTH'(14): hdr_fail_s = (in_dout[7:4] != IP_VERSION_DEF) ||
                                   (in_dout[3:0] != IP_HEADER_LENGTH_DEF);
      CNT_WIDTH'(23): hdr_fail_s = (in_dout != UDP_PROTOCOL_DEF);
      CNT_WIDTH'(37): hdr_fail_s = FILTER_PORT && ({cap_udp_dst_q[7:0], in_dout} != DST_PORT);
      CNT_WIDTH'(39): hdr_fail_s = ({cap_udp_len_q[7:0], in_dout} < 16'd8);
      default:        hdr_fail_s = 1'b0;
    endcase
  end

  // Next-state, field capture and counter logic for the parse sequencer.
  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    pay_cnt_d     = pay_cnt_q;
    eth_hi_d      = eth_hi_q;
    cap_ip_src_d  = cap_ip_src_q;
    cap_ip_dst_d  = cap_ip_dst_q;
    cap_udp_src_d = cap_udp_src_q;
    cap_udp_dst_d = cap_udp_dst_q;
    cap_udp_len_d = cap_udp_len_q;
    ip_src_d      = ip_src_q;
    ip_dst_d      = ip_dst_q;
    udp_src_d     = udp_src_q;
    udp_dst_d     = udp_dst_q;
    udp_len_d     = udp_len_q;
    hdr_valid_d   = 1'b0;
    pkt_drop_d    = 1'b0;
    pkt_cnt_d     = pkt_cnt_q;
    drop_cnt_d    = drop_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_rd_en && in_sof && in_eof) begin
          pkt_drop_d = 1'b1;
          drop_cnt_d = sat_inc(drop_cnt_q);
        end else if (in_rd_en && in_sof) begin
          state_d    = S_HDR;
          byte_cnt_d = CNT_WIDTH'(1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HDR: begin
        if (in_rd_en) begin
          byte_cnt_d = byte_cnt_q + CNT_WIDTH'(1);
          // Multi-byte fields are big-endian, so shift each byte in from the right.
          case (byte_cnt_q)
            CNT_WIDTH'(12): eth_hi_d = in_dout;
            CNT_WIDTH'(26), CNT_WIDTH'(27), CNT_WIDTH'(28), CNT_WIDTH'(29):
              cap_ip_src_d = {cap_ip_src_q[23:0], in_dout};
            CNT_WIDTH'(30), CNT_WIDTH'(31), CNT_WIDTH'(32), CNT_WIDTH'(33):
              cap_ip_dst_d = {cap_ip_dst_q[23:0], in_dout};
            CNT_WIDTH'(34), CNT_WIDTH'(35): cap_udp_src_d = {cap_udp_src_q[7:0], in_dout};
            CNT_WIDTH'(36), CNT_WIDTH'(37): cap_udp_dst_d = {cap_udp_dst_q[7:0], in_dout};
            CNT_WIDTH'(38), CNT_WIDTH'(39): cap_udp_len_d = {cap_udp_len_q[7:0], in_dout};
            default: eth_hi_d = eth_hi_q;
          endcase
          if (hdr_fail_s || (in_eof && (byte_cnt_q != HDR_LAST))) begin
            pkt_drop_d = 1'b1;
            drop_cnt_d = sat_inc(drop_cnt_q);
            state_d    = in_eof ? S_IDLE : S_DROP;
          end else if (byte_cnt_q == HDR_LAST) begin
            // Publish the shadow fields so outputs hold steady through the next header.
            hdr_valid_d = 1'b1;
            pkt_cnt_d   = sat_inc(pkt_cnt_q);
            ip_src_d    = cap_ip_src_q;
            ip_dst_d    = cap_ip_dst_q;
            udp_src_d   = cap_udp_src_q;
            udp_dst_d   = cap_udp_dst_q;
            udp_len_d   = cap_udp_len_q;
            pay_cnt_d   = '0;
            if (in_eof) begin
              state_d    = S_IDLE;
              pkt_drop_d = (cap_udp_len_q != 16'd8);
            end else begin
              state_d = (cap_udp_len_q == 16'd8) ? S_TRAIL : S_PAYLOAD;
            end
          end else begin
            state_d = S_HDR;
          end
        end else begin
          state_d = S_HDR;
        end
      end
      S_PAYLOAD: begin
        if (in_rd_en) begin
          pay_cnt_d = pay_cnt_q + CNT_WIDTH'(1);
          if (in_eof) begin
            state_d    = S_IDLE;
            pkt_drop_d = !pay_last_s;
          end else if (pay_last_s) begin
            state_d = S_TRAIL;
          end else begin
            state_d = S_PAYLOAD;
          end
        end else begin
          state_d = S_PAYLOAD;
        end
      end
      S_TRAIL, S_DROP: begin
        if (in_rd_en && in_eof) begin
          state_d = S_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; asynchronous reset clears everything.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      byte_cnt_q    <= '0;
      pay_cnt_q     <= '0;
      eth_hi_q      <= 8'h00;
      cap_ip_src_q  <= 32'h0;
      cap_ip_dst_q  <= 32'h0;
      cap_udp_src_q <= 16'h0;
      cap_udp_dst_q <= 16'h0;
      cap_udp_len_q <= 16'h0;
      ip_src_q      <= 32'h0;
      ip_dst_q      <= 32'h0;
      udp_src_q     <= 16'h0;
      udp_dst_q     <= 16'h0;
      udp_len_q     <= 16'h0;
      hdr_valid_q   <= 1'b0;
      pkt_drop_q    <= 1'b0;
      pkt_cnt_q     <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      pay_cnt_q     <= pay_cnt_d;
      eth_hi_q      <= eth_hi_d;
      cap_ip_src_q  <= cap_ip_src_d;
      cap_ip_dst_q  <= cap_ip_dst_d;
      cap_udp_src_q <= cap_udp_src_d;
      cap_udp_dst_q <= cap_udp_dst_d;
      cap_udp_len_q <= cap_udp_len_d;
      ip_src_q      <= ip_src_d;
      ip_dst_q      <= ip_dst_d;
      udp_src_q     <= udp_src_d;
      udp_dst_q     <= udp_dst_d;
      udp_len_q     <= udp_len_d;
      hdr_valid_q   <= hdr_valid_d;
      pkt_drop_q    <= pkt_drop_d;
      pkt_cnt_q     <= pkt_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign ip_src    = ip_src_q;
  assign ip_dst    = ip_dst_q;
  assign udp_src   = udp_src_q;
  assign udp_dst   = udp_dst_q;
  assign udp_len   = udp_len_q;
  assign hdr_valid = hdr_valid_q;
  assign pkt_drop  = pkt_drop_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_udp_parse_ctrl.sv
// Directed bench for udp_parse_ctrl: builds frames byte by byte, drives the
// FWFT handshake and compares payload stream, pulses and fields to hand values.
module tb_udp_parse_ctrl;

  logic        clock, reset_n;
  logic [7:0]  in_dout;
  logic        in_sof, in_eof, in_empty, in_rd_en;
  logic [7:0]  out_din;
  logic        out_sof, out_eof, out_wr_en, out_full;
  logic        hdr_valid, pkt_drop;
  logic [31:0] ip_src, ip_dst;
  logic [15:0] udp_src, udp_dst, udp_len;
  logic [15:0] pkt_cnt, drop_cnt;

  udp_parse_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .in_dout(in_dout), .in_sof(in_sof), .in_eof(in_eof), .in_empty(in_empty),
    .in_rd_en(in_rd_en),
    .out_din(out_din), .out_sof(out_sof), .out_eof(out_eof), .out_wr_en(out_wr_en),
    .out_full(out_full),
    .hdr_valid(hdr_valid), .ip_src(ip_src), .ip_dst(ip_dst),
    .udp_src(udp_src), .udp_dst(udp_dst), .udp_len(udp_len),
    .pkt_drop(pkt_drop), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] fb[$];
  bit         fsof[$];
  bit         feof[$];
  logic [7:0] gb[$];
  bit         gs[$];
  bit         ge[$];
  int         hv_cnt = 0;
  int         pd_cnt = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Collect written payload bytes and output pulses away from the rising edge.
  always @(negedge clock) begin
    if (reset_n) begin
      if (out_wr_en) begin
        gb.push_back(out_din);
        gs.push_back(out_sof);
        ge.push_back(out_eof);
      end
      if (hdr_valid) hv_cnt++;
      if (pkt_drop) pd_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_obs();
    gb.delete(); gs.delete(); ge.delete();
    hv_cnt = 0;
    pd_cnt = 0;
  endtask

  // Append one frame to the stimulus queue; payload bytes are A1, A2, ...
  task automatic build(input logic [15:0] etype, input logic [31:0] src, input logic [31:0] dst,
                       input logic [15:0] sp, input logic [15:0] dp, input logic [15:0] ulen,
                       input int npay, input int total);
    for (int k = 0; k < total; k++) begin
      logic [7:0] b;
      b = 8'h00;
      if (k < 12)                     b = 8'h20 + 8'(k);
      else if (k == 12)               b = etype[15:8];
      else if (k == 13)               b = etype[7:0];
      else if (k == 14)               b = 8'h45;
      else if (k == 23)               b = 8'h11;
      else if (k >= 26 && k <= 29)    b = src[8*(29-k) +: 8];
      else if (k >= 30 && k <= 33)    b = dst[8*(33-k) +: 8];
      else if (k >= 34 && k <= 35)    b = sp[8*(35-k) +: 8];
      else if (k >= 36 && k <= 37)    b = dp[8*(37-k) +: 8];
      else if (k >= 38 && k <= 39)    b = ulen[8*(39-k) +: 8];
      else if (k >= 42 && k < 42+npay) b = 8'hA1 + 8'(k - 42);
      else                            b = 8'h00;
      fb.push_back(b);
      fsof.push_back(k == 0);
      feof.push_back(k == total - 1);
    end
  endtask

  // Present bytes [first, last) through the FWFT handshake, optionally stalling.
  task automatic send_range(input int first, input int last, input bit stall);
    int i;
    int cyc;
    i = first;
    cyc = 0;
    while (i < last && cyc < 3000) begin
      @(posedge clock); #1;
      in_empty = stall ? ($urandom_range(0, 2) == 0) : 1'b0;
      out_full = stall ? ~out_full : 1'b0;
      in_dout  = fb[i];
      in_sof   = fsof[i];
      in_eof   = feof[i];
      #1;
      if (in_rd_en) i++;
      cyc++;
    end
    @(posedge clock); #1;
    in_empty = 1'b1; in_sof = 1'b0; in_eof = 1'b0; out_full = 1'b0;
    check("bytes_consumed", i, last);
  endtask

  task automatic send_all(input bit stall);
    send_range(0, fb.size(), stall);
    fb.delete(); fsof.delete(); feof.delete();
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic check_stream(input string tag, input int n);
    check({tag, "_nbytes"}, gb.size(), n);
    for (int k = 0; k < n; k++) begin
      if (k < gb.size()) begin
        check({tag, "_byte"}, gb[k], 8'hA1 + 8'(k));
        check({tag, "_sof"}, gs[k], (k == 0));
        check({tag, "_eof"}, ge[k], (k == n - 1));
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; in_dout = 8'h55; in_sof = 1'b1; in_eof = 1'b0;
    in_empty = 1'b0; out_full = 1'b0;
    #12;
    // Reset state: every output low even with a byte waiting.
    check("rst_rd_en", in_rd_en, 1'b0);
    check("rst_wr_en", out_wr_en, 1'b0);
    check("rst_hdr_valid", hdr_valid, 1'b0);
    check("rst_pkt_drop", pkt_drop, 1'b0);
    check("rst_pkt_cnt", pkt_cnt, 16'd0);
    check("rst_drop_cnt", drop_cnt, 16'd0);
    check("rst_ip_src", ip_src, 32'h0);
    check("rst_udp_len", udp_len, 16'h0);
    in_empty = 1'b1; in_sof = 1'b0;
    @(negedge clock); reset_n = 1'b1;

    // 1: basic valid frame, 4 payload bytes.
    clear_obs();
    build(16'h0800, 32'hC0A80001, 32'h0A000002, 16'h1234, 16'h5678, 16'h000C, 4, 46);
    send_all(1'b0);
    check_stream("t1", 4);
    check("t1_hdr_valid", hv_cnt, 1);
    check("t1_pkt_drop", pd_cnt, 0);
    check("t1_pkt_cnt", pkt_cnt, 16'd1);
    check("t1_drop_cnt", drop_cnt, 16'd0);
    check("t1_ip_src", ip_src, 32'hC0A80001);
    check("t1_ip_dst", ip_dst, 32'h0A000002);
    check("t1_udp_src", udp_src, 16'h1234);
    check("t1_udp_dst", udp_dst, 16'h5678);
    check("t1_udp_len", udp_len, 16'h000C);

    // 2: IPv6 ethertype is rejected; published fields keep frame 1 values.
    clear_obs();
    build(16'h86DD, 32'h11111111, 32'h22222222, 16'h0001, 16'h0002, 16'h000C, 4, 60);
    send_all(1'b0);
    check("t2_nbytes", gb.size(), 0);
    check("t2_pkt_drop", pd_cnt, 1);
    check("t2_hdr_valid", hv_cnt, 0);
    check("t2_drop_cnt", drop_cnt, 16'd1);
    check("t2_pkt_cnt", pkt_cnt, 16'd1);
    check("t2_ip_src_held", ip_src, 32'hC0A80001);

    // 3: 60-byte frame with Ethernet padding, udp_len=10.
    clear_obs();
    build(16'h0800, 32'h01020304, 32'h05060708, 16'h0400, 16'h0800, 16'h000A, 2, 60);
    send_all(1'b0);
    check_stream("t3", 2);
    check("t3_pkt_cnt", pkt_cnt, 16'd2);
    check("t3_udp_len", udp_len, 16'h000A);
    check("t3_pkt_drop", pd_cnt, 0);

    // 4: frame 1 again under out_full toggling and random in_empty.
    clear_obs();
    build(16'h0800, 32'hC0A80001, 32'h0A000002, 16'h1234, 16'h5678, 16'h000C, 4, 46);
    send_all(1'b1);
    check_stream("t4", 4);
    check("t4_pkt_cnt", pkt_cnt, 16'd3);
    check("t4_hdr_valid", hv_cnt, 1);

    // 5: runt ending at byte 30, then back-to-back frame with a 1-byte payload.
    clear_obs();
    build(16'h0800, 32'hDEADBEEF, 32'hCAFEF00D, 16'h0007, 16'h0009, 16'h000C, 4, 31);
    build(16'h0800, 32'hAC100001, 32'hAC100002, 16'h2222, 16'h3333, 16'h0009, 1, 60);
    send_all(1'b0);
    check("t5_pkt_drop", pd_cnt, 1);
    check("t5_drop_cnt", drop_cnt, 16'd2);
    check_stream("t5", 1);
    check("t5_pkt_cnt", pkt_cnt, 16'd4);
    check("t5_ip_src", ip_src, 32'hAC100001);
    check("t5_udp_dst", udp_dst, 16'h3333);

    // 6: reset mid-payload, rest of frame discarded, next frame parsed cleanly.
    clear_obs();
    build(16'h0800, 32'h0B0B0B0B, 32'h0C0C0C0C, 16'h0101, 16'h0202, 16'h0014, 12, 54);
    send_range(0, 45, 1'b0);
    check("t6_pre_bytes", gb.size(), 3);
    in_dout = fb[45]; in_empty = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check("t6_rst_rd_en", in_rd_en, 1'b0);
    check("t6_rst_wr_en", out_wr_en, 1'b0);
    check("t6_rst_pkt_cnt", pkt_cnt, 16'd0);
    check("t6_rst_drop_cnt", drop_cnt, 16'd0);
    check("t6_rst_ip_src", ip_src, 32'h0);
    check("t6_rst_udp_len", udp_len, 16'h0);
    in_empty = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock); reset_n = 1'b1;
    clear_obs();
    send_range(45, fb.size(), 1'b0);
    fb.delete(); fsof.delete(); feof.delete();
    check("t6_tail_nbytes", gb.size(), 0);
    check("t6_tail_pkt_cnt", pkt_cnt, 16'd0);
    build(16'h0800, 32'hC0A80001, 32'h0A000002, 16'h1234, 16'h5678, 16'h000C, 4, 46);
    send_all(1'b0);
    check_stream("t6", 4);
    check("t6_pkt_cnt", pkt_cnt, 16'd1);
    check("t6_drop_cnt", drop_cnt, 16'd0);
    check("t6_ip_dst", ip_dst, 32'h0A000002);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
